// File: rtl/key_onehot_scanner_pkg.sv
// Shared types for the key scanner: key count, FSM state encoding, one-hot test.
package key_scan_pkg;

   localparam int N_KEYS = 8;

   typedef enum logic [1:0] {IDLE, HELD, LOCKOUT} scan_state_t;

   // A vector with exactly one set bit: nonzero, and clearing its lowest set bit leaves zero.
   function automatic logic is_onehot(input logic [N_KEYS-1:0] v);
      return (v != '0) && ((v & (v - N_KEYS'(1))) == '0);
   endfunction

endpackage

// File: rtl/key_onehot_scanner_if.sv
// Raw key levels in, clean one-hot key plus event pulses out.
interface key_onehot_scanner_if;
   import key_scan_pkg::*;

   logic [N_KEYS-1:0] key_raw;
   logic [N_KEYS-1:0] onehot;
   logic              key_valid;
   logic              key_strobe;
   logic              multi_err;

   modport master (output key_raw, input onehot, key_valid, key_strobe, multi_err);
   modport slave  (input key_raw, output onehot, key_valid, key_strobe, multi_err);
endinterface

// File: rtl/key_onehot_scanner_debounce.sv
// One key bit: 2-flop synchronizer, then a run-length debouncer.
// Debounced bit flips DEBOUNCE_CYCLES+2 edges after a stable input change; no backpressure.
module key_debounce #(
   parameter  int DEBOUNCE_CYCLES = 16,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic deb
);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
         cnt  <= '0;
         deb  <= 1'b0;
      end else begin
         sync <= {sync[0], key_raw};
         // Any cycle of agreement restarts the run, so bounces never accumulate.
         if (sync[1] == deb) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb <= ~deb;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/key_onehot_scanner.sv
// Debounces eight keys and admits at most one to the registered one-hot output.
// Output follows debounced vector by one edge; no backpressure, pulses are single-cycle.
module key_onehot_scanner
   import key_scan_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   key_onehot_scanner_if.slave kif
);

   logic [N_KEYS-1:0] deb;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_deb
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk     (clk),
         .rst_n   (rst_n),
         .key_raw (kif.key_raw[i]),
         .deb     (deb[i])
      );
   end

   scan_state_t       state_q,  state_d;
   logic [N_KEYS-1:0] onehot_q, onehot_d;
   logic              strobe_q, strobe_d;
   logic              multi_q,  multi_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         onehot_q <= '0;
         strobe_q <= 1'b0;
         multi_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         onehot_q <= onehot_d;
         strobe_q <= strobe_d;
         multi_q  <= multi_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      onehot_d = onehot_q;
      strobe_d = 1'b0;
      multi_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (is_onehot(deb)) begin
               state_d  = HELD;
               onehot_d = deb;
               strobe_d = 1'b1;
            end else if (deb != '0) begin
               state_d = LOCKOUT;
               multi_d = 1'b1;
            end
         end
         HELD: begin
            if (deb == '0) begin
               state_d  = IDLE;
               onehot_d = '0;
            end else if (deb != onehot_q) begin
               // Added key or a swap to a different key both count as ambiguous.
               state_d  = LOCKOUT;
               onehot_d = '0;
               multi_d  = 1'b1;
            end
         end
         LOCKOUT: begin
            if (deb == '0) state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            onehot_d = '0;
         end
      endcase
   end

   assign kif.onehot     = onehot_q;
   assign kif.key_valid  = |onehot_q;
   assign kif.key_strobe = strobe_q;
   assign kif.multi_err  = multi_q;

endmodule

// File: tb/tb_key_onehot_scanner.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor checks them.
module tb_key_onehot_scanner;

   localparam int DB  = 4;
   localparam int LAT = DB + 2;  // edges from first sampling edge to output update, minus one

   localparam logic [1:0] K_STROBE = 2'd0;
   localparam logic [1:0] K_MULTI  = 2'd1;
   localparam logic [1:0] K_REL    = 2'd2;
   localparam logic [1:0] K_BAD    = 2'd3;

   typedef struct {
      logic [1:0] kind;
      logic [7:0] oh;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sbq[$];

   key_onehot_scanner_if kif();

   key_onehot_scanner #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kif   (kif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every output event must match the head of the scoreboard.
   logic [7:0] prev_oh = 8'h00;
   always @(negedge clk) begin
      logic [1:0] got_kind;
      exp_t       e;
      checks++;
      if (kif.key_valid !== (|kif.onehot) || (kif.onehot & (kif.onehot - 8'h01)) != 8'h00) begin
         errors++;
         $display("FAIL invariant: onehot=%h key_valid=%b required onehot-or-zero with matching valid",
                  kif.onehot, kif.key_valid);
      end
      if (kif.key_strobe || kif.multi_err || kif.onehot != prev_oh) begin
         if (kif.key_strobe && kif.multi_err) got_kind = K_BAD;
         else if (kif.key_strobe)             got_kind = K_STROBE;
         else if (kif.multi_err)              got_kind = K_MULTI;
         else                                 got_kind = K_REL;
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: cyc=%0d kind=%0d onehot=%h required no event",
                     cyc, got_kind, kif.onehot);
         end else begin
            e = sbq.pop_front();
            if (got_kind != e.kind || kif.onehot !== e.oh || kif.key_valid !== (|e.oh)) begin
               errors++;
               $display("FAIL event_value: kind=%0d onehot=%h valid=%b required kind=%0d onehot=%h valid=%b",
                        got_kind, kif.onehot, kif.key_valid, e.kind, e.oh, |e.oh);
            end
            checks++;
            if (cyc != e.cyc) begin
               errors++;
               $display("FAIL event_edge: edge=%0d required edge=%0d", cyc, e.cyc);
            end
         end
      end
      prev_oh = kif.onehot;
   end

   task automatic push(input logic [1:0] kind, input logic [7:0] oh, input int at);
      exp_t e;
      e.kind = kind;
      e.oh   = oh;
      e.cyc  = at;
      sbq.push_back(e);
   endtask

   // Drive new key levels between edges; the next edge is the first to sample them.
   task automatic drive(input logic [7:0] v, input logic expect_ev,
                        input logic [1:0] kind, input logic [7:0] oh);
      @(negedge clk);
      kif.key_raw = v;
      if (expect_ev) push(kind, oh, cyc + 1 + LAT);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: %0d events pending, required 0", name, sbq.size());
         sbq.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic chk_idle(input string name);
      checks++;
      if (kif.onehot !== 8'h00 || kif.key_valid !== 1'b0 ||
          kif.key_strobe !== 1'b0 || kif.multi_err !== 1'b0) begin
         errors++;
         $display("FAIL %s: onehot=%h valid=%b strobe=%b multi=%b required all zero",
                  name, kif.onehot, kif.key_valid, kif.key_strobe, kif.multi_err);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      kif.key_raw = 8'hFF;

      // 1: all keys down through reset, seen as multi-key after release
      repeat (4) begin
         @(negedge clk);
         chk_idle("reset_outputs");
      end
      rst_n = 1'b1;
      push(K_MULTI, 8'h00, cyc + 1 + LAT);
      drain("t1_multi");
      drive(8'h00, 1'b0, K_REL, 8'h00);
      repeat (10) @(posedge clk);

      // 2: single key press and release
      drive(8'h04, 1'b1, K_STROBE, 8'h04);
      drain("t2_press");
      repeat (5) @(posedge clk);
      drive(8'h00, 1'b1, K_REL, 8'h00);
      drain("t2_release");

      // 3: bouncing bit 5, then stable press
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         kif.key_raw = (i % 2 == 0) ? 8'h20 : 8'h00;
         @(negedge clk);
      end
      drive(8'h20, 1'b1, K_STROBE, 8'h20);
      drain("t3_press");
      drive(8'h00, 1'b1, K_REL, 8'h00);
      drain("t3_release");

      // 4: two keys together, then a clean single key
      drive(8'h11, 1'b1, K_MULTI, 8'h00);
      drain("t4_multi");
      drive(8'h00, 1'b0, K_REL, 8'h00);
      repeat (10) @(posedge clk);
      drive(8'h80, 1'b1, K_STROBE, 8'h80);
      drain("t4_press");
      drive(8'h00, 1'b1, K_REL, 8'h00);
      drain("t4_release");

      // 5: held key joined by a second, partial release must not re-arm
      drive(8'h02, 1'b1, K_STROBE, 8'h02);
      drain("t5_press");
      drive(8'h0A, 1'b1, K_MULTI, 8'h00);
      drain("t5_multi");
      drive(8'h02, 1'b0, K_REL, 8'h00);
      repeat (12) @(posedge clk);
      drive(8'h00, 1'b0, K_REL, 8'h00);
      repeat (12) @(posedge clk);
      drive(8'h01, 1'b1, K_STROBE, 8'h01);
      drain("t5_press2");
      drive(8'h00, 1'b1, K_REL, 8'h00);
      drain("t5_release");

      // 6: asynchronous reset pulse while a key is held
      drive(8'h40, 1'b1, K_STROBE, 8'h40);
      drain("t6_press");
      @(negedge clk);
      #1 rst_n = 1'b0;
      push(K_REL, 8'h00, cyc + 1);
      #1 chk_idle("t6_async_reset");
      #1 rst_n = 1'b1;
      push(K_STROBE, 8'h40, cyc + 1 + LAT);
      drain("t6_reacquire");
      drive(8'h00, 1'b1, K_REL, 8'h00);
      drain("t6_release");

      @(negedge clk);
      chk_idle("final_idle");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
